// File: rtl/stream_map_op_pkg.sv
// Shared FSM state encoding and map-operation codes for the stream_map_op job engine.
package stream_map_op_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MAP_ADD  = 0;
    localparam int MAP_SUB  = 1;
    localparam int MAP_SATU = 2;
    localparam int MAP_SATS = 3;

endpackage

// File: rtl/stream_map_op_fifo.sv
// DEPTH-entry result buffer: registered write, head read straight from memory (latency 1 when empty).
// Push is ignored when full and pop when empty; simultaneous push/pop keeps the count.
module stream_map_op_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_head_dat = r_mem[r_rptr];

    // Pointers are AW bits wide, so they wrap mod DEPTH for free.
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_push_dat;
    end

endmodule

// File: rtl/stream_map_op.sv
// Length-bounded job: start handshake gives a count, that many elements are mapped through a fixed op
// into a FIFO, then a done handshake; sIn_ready depends only on state/count/fullness, never sOut_ready.
module stream_map_op
    import stream_map_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LENW  = 8,
    parameter int MODE  = 0,
    parameter int K     = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LENW-1:0]  in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    input  logic [WIDTH-1:0] sIn,
    input  logic             sIn_valid,
    output logic             sIn_ready,
    output logic [WIDTH-1:0] sOut,
    output logic             sOut_valid,
    input  logic             sOut_ready
);

    localparam logic [WIDTH-1:0] K_W = WIDTH'(K);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LENW-1:0]  r_remaining;
    logic             r_ovf;

    logic             w_start;
    logic             w_accept;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic             w_sovf;
    logic [WIDTH-1:0] w_y;
    logic             w_elem_ovf;

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign sIn_ready  = (r_state == RUN) && (r_remaining != '0) && !w_fifo_full;
    assign sOut_valid = !w_fifo_empty;
    assign ovf        = r_ovf;
    assign w_start    = in_valid && in_ready;
    assign w_accept   = sIn_valid && sIn_ready;

    // Extra top bit carries the unsigned carry/borrow out.
    assign w_sum  = {1'b0, sIn} + {1'b0, K_W};
    assign w_dif  = {1'b0, sIn} - {1'b0, K_W};
    assign w_sovf = (sIn[WIDTH-1] == K_W[WIDTH-1]) && (w_sum[WIDTH-1] != sIn[WIDTH-1]);

    always_comb begin
        w_y        = w_sum[WIDTH-1:0];
        w_elem_ovf = w_sum[WIDTH];
        case (MODE)
            MAP_SUB: begin
                w_y        = w_dif[WIDTH-1:0];
                w_elem_ovf = w_dif[WIDTH];
            end
            MAP_SATU: begin
                if (w_sum[WIDTH]) w_y = '1;
            end
            MAP_SATS: begin
                w_elem_ovf = w_sovf;
                // Signed overflow can only happen toward the sign of the operands.
                if (w_sovf)
                    w_y = sIn[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = (in_len != '0) ? RUN : DONE;
            RUN:     if (w_accept && (r_remaining == LENW'(1))) w_state_nxt = DRAIN;
            DRAIN:   if (w_fifo_empty) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_remaining <= in_len;
                r_ovf       <= 1'b0;
            end else if (w_accept) begin
                r_remaining <= r_remaining - LENW'(1);
                r_ovf       <= r_ovf | w_elem_ovf;
            end
        end
    end

    stream_map_op_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .nrst       (nrst),
        .i_push     (w_accept),
        .i_push_dat (w_y),
        .i_pop      (sOut_ready),
        .o_head_dat (sOut),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

endmodule

// File: tb/tb_stream_map_op.sv
// Directed bench: four instances (MODE 0..3, K=1) share stimulus; instance 0 drives the handshake timing.
module tb_stream_map_op;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_len = '0;
    logic       out_ready = 1'b0;
    logic [7:0] sIn = '0;
    logic       sIn_valid = 1'b0;
    logic       sOut_ready = 1'b0;

    logic [3:0] in_rdy;
    logic [3:0] out_vld;
    logic [3:0] ovf_w;
    logic [3:0] sin_rdy;
    logic [3:0] sout_vld;
    logic [7:0] sout_dat [4];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] q3[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        stream_map_op #(
            .WIDTH (8),
            .DEPTH (4),
            .LENW  (8),
            .MODE  (g),
            .K     (1)
        ) u_dut (
            .clk        (clk),
            .nrst       (nrst),
            .in_valid   (in_valid),
            .in_ready   (in_rdy[g]),
            .in_len     (in_len),
            .out_valid  (out_vld[g]),
            .out_ready  (out_ready),
            .ovf        (ovf_w[g]),
            .sIn        (sIn),
            .sIn_valid  (sIn_valid),
            .sIn_ready  (sin_rdy[g]),
            .sOut       (sout_dat[g]),
            .sOut_valid (sout_vld[g]),
            .sOut_ready (sOut_ready)
        );
    end

    // Record every popped element of each instance; sampled mid-cycle where all signals are stable.
    always @(negedge clk) begin
        if (!nrst && sOut_ready) begin
            if (sout_vld[0]) q0.push_back(sout_dat[0]);
            if (sout_vld[1]) q1.push_back(sout_dat[1]);
            if (sout_vld[2]) q2.push_back(sout_dat[2]);
            if (sout_vld[3]) q3.push_back(sout_dat[3]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] len);
        in_valid = 1'b1;
        in_len   = len;
        step();
        in_valid = 1'b0;
    endtask

    task automatic push_elem(input logic [7:0] v);
        bit ok;
        ok        = 1'b0;
        sIn       = v;
        sIn_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (sin_rdy[0]) ok = 1'b1;
            step();
        end
        sIn_valid = 1'b0;
        check("push accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (out_vld[0]) ok = 1'b1;
            else step();
        end
        check("done reached", 32'(ok), 32'd1);
    endtask

    task automatic ack_done();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("back to idle", 32'(in_rdy[0]), 32'd1);
    endtask

    initial begin
        int base;
        int idx;

        // Reset state
        nrst = 1'b1;
        step();
        step();
        nrst = 1'b0;
        check("rst in_ready",   32'(in_rdy[0]),   32'd1);
        check("rst out_valid",  32'(out_vld[0]),  32'd0);
        check("rst sIn_ready",  32'(sin_rdy[0]),  32'd0);
        check("rst sOut_valid", 32'(sout_vld[0]), 32'd0);
        check("rst ovf",        32'(ovf_w[0]),    32'd0);

        // 1: MODE0 add-1 over 0..3, sink always ready
        sOut_ready = 1'b1;
        base = q0.size();
        start_job(8'd4);
        check("t1 run sIn_ready",  32'(sin_rdy[0]),  32'd1);
        check("t1 pre sOut_valid", 32'(sout_vld[0]), 32'd0);
        sIn_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sIn = 8'(i);
            step();
            if (i == 0) begin
                check("t1 lat sOut_valid", 32'(sout_vld[0]), 32'd1);
                check("t1 lat sOut",       32'(sout_dat[0]), 32'd1);
            end
        end
        sIn_valid = 1'b0;
        wait_done();
        check("t1 ovf", 32'(ovf_w[0]), 32'd0);
        check("t1 count", 32'(q0.size() - base), 32'd4);
        for (int i = 0; i < 4; i++)
            if (base + i < q0.size()) check("t1 data", 32'(q0[base+i]), 32'(i + 1));
        ack_done();

        // 2: backpressure with a full FIFO, then release
        sOut_ready = 1'b0;
        base = q0.size();
        start_job(8'd6);
        idx = 0;
        sIn_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sIn = 8'(idx);
            @(negedge clk);
            if (sin_rdy[0]) idx++;
            step();
        end
        check("t2 accepted while full", 32'(idx), 32'd4);
        check("t2 full sIn_ready",      32'(sin_rdy[0]),  32'd0);
        check("t2 full sOut_valid",     32'(sout_vld[0]), 32'd1);
        sOut_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            sIn = 8'(idx);
            @(negedge clk);
            if (sin_rdy[0]) idx++;
            step();
        end
        sIn_valid = 1'b0;
        check("t2 total accepted", 32'(idx), 32'd6);
        wait_done();
        check("t2 count", 32'(q0.size() - base), 32'd6);
        for (int i = 0; i < 6; i++)
            if (base + i < q0.size()) check("t2 order", 32'(q0[base+i]), 32'(i + 1));
        check("t2 ovf", 32'(ovf_w[0]), 32'd0);
        ack_done();

        // 3: boundary arithmetic for every mode, inputs 255,127,0
        base = q0.size();
        start_job(8'd3);
        push_elem(8'd255);
        push_elem(8'd127);
        push_elem(8'd0);
        wait_done();
        check("t3 m0 count", 32'(q0.size() - base), 32'd3);
        check("t3 m1 count", 32'(q1.size() - base), 32'd3);
        check("t3 m2 count", 32'(q2.size() - base), 32'd3);
        check("t3 m3 count", 32'(q3.size() - base), 32'd3);
        if (q0.size() >= base + 3 && q1.size() >= base + 3 && q2.size() >= base + 3 && q3.size() >= base + 3) begin
            check("t3 m0 255", 32'(q0[base]),   32'd0);
            check("t3 m0 127", 32'(q0[base+1]), 32'd128);
            check("t3 m0 0",   32'(q0[base+2]), 32'd1);
            check("t3 m1 255", 32'(q1[base]),   32'd254);
            check("t3 m1 127", 32'(q1[base+1]), 32'd126);
            check("t3 m1 0",   32'(q1[base+2]), 32'd255);
            check("t3 m2 255", 32'(q2[base]),   32'd255);
            check("t3 m2 127", 32'(q2[base+1]), 32'd128);
            check("t3 m2 0",   32'(q2[base+2]), 32'd1);
            check("t3 m3 255", 32'(q3[base]),   32'd0);
            check("t3 m3 127", 32'(q3[base+1]), 32'd127);
            check("t3 m3 0",   32'(q3[base+2]), 32'd1);
        end
        check("t3 ovf all", 32'(ovf_w), 32'hF);
        ack_done();

        // 4+6: zero-length job, then done held without acknowledge
        start_job(8'd0);
        check("t4 done next cycle", 32'(out_vld[0]), 32'd1);
        check("t4 sIn_ready",       32'(sin_rdy[0]), 32'd0);
        check("t4 ovf cleared",     32'(ovf_w),      32'h0);
        in_valid = 1'b1;
        in_len   = 8'd3;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t6 out_valid held", 32'(out_vld[0]), 32'd1);
            check("t6 in_ready low",   32'(in_rdy[0]),  32'd0);
        end
        in_valid = 1'b0;
        ack_done();
        check("t6 out_valid dropped", 32'(out_vld[0]), 32'd0);
        step();
        check("t6 no job started", 32'(sin_rdy[0]), 32'd0);
        check("t6 still idle",     32'(in_rdy[0]),  32'd1);

        // 5: reset in the middle of a job with three entries buffered
        sOut_ready = 1'b0;
        start_job(8'd6);
        push_elem(8'd10);
        push_elem(8'd20);
        push_elem(8'd30);
        check("t5 buffered", 32'(sout_vld[0]), 32'd1);
        nrst = 1'b1;
        step();
        nrst = 1'b0;
        check("t5 sOut_valid", 32'(sout_vld[0]), 32'd0);
        check("t5 in_ready",   32'(in_rdy[0]),   32'd1);
        check("t5 out_valid",  32'(out_vld[0]),  32'd0);
        check("t5 sIn_ready",  32'(sin_rdy[0]),  32'd0);
        sOut_ready = 1'b1;
        base = q0.size();
        start_job(8'd2);
        push_elem(8'd7);
        push_elem(8'd8);
        wait_done();
        check("t5 new count", 32'(q0.size() - base), 32'd2);
        if (q0.size() >= base + 2) begin
            check("t5 new d0", 32'(q0[base]),   32'd8);
            check("t5 new d1", 32'(q0[base+1]), 32'd9);
        end
        check("t5 new ovf", 32'(ovf_w[0]), 32'd0);
        ack_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
